// File: rtl/alarm_countdown_timer.sv
// Seconds countdown timer for the alarm controller: loads a duration on start_timer,
// decrements once per prescaler period, pulses expired at zero, and emits 1 Hz / 0.5 Hz strobes.
module alarm_countdown_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int VALUE_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_timer,
  input  logic [VALUE_W-1:0] value,
  output logic               expired,
  output logic               one_hz_enable,
  output logic               half_hz_enable,
  output logic [VALUE_W-1:0] value_display,
  output logic               busy
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               phase_q, phase_d;
  logic [VALUE_W-1:0] count_q, count_d;
  logic               expired_q, expired_d;
  logic               tick;

  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      phase_q   <= 1'b0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    phase_d   = tick ? ~phase_q : phase_q;
    count_d   = count_q;
    expired_d = 1'b0;

    if (start_timer) begin
      // A (re)load realigns the second boundary and suppresses any coincident expiry.
      presc_d   = '0;
      phase_d   = 1'b0;
      count_d   = value;
      if (value != '0) begin
        state_d = RUNNING;
      end else begin
        state_d   = IDLE;
        expired_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
        end
        RUNNING: begin
          if (tick) begin
            if (count_q <= VALUE_W'(1)) begin
              count_d   = '0;
              state_d   = IDLE;
              expired_d = 1'b1;
            end else begin
              count_d = count_q - VALUE_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign one_hz_enable  = tick;
  assign half_hz_enable = tick & phase_q;
  assign expired        = expired_q;
  assign value_display  = count_q;
  assign busy           = (state_q == RUNNING);

endmodule

// File: tb/tb_alarm_countdown_timer.sv
// Directed bench for alarm_countdown_timer with a 10-cycle prescaler.
module tb_alarm_countdown_timer;

  localparam int CLK_HZ  = 10;
  localparam int VALUE_W = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start_timer = 1'b0;
  logic [VALUE_W-1:0] value = '0;
  logic               expired;
  logic               one_hz_enable;
  logic               half_hz_enable;
  logic [VALUE_W-1:0] value_display;
  logic               busy;

  int total = 0;
  int bad   = 0;

  alarm_countdown_timer #(
    .CLK_HZ (CLK_HZ),
    .VALUE_W(VALUE_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_timer   (start_timer),
    .value         (value),
    .expired       (expired),
    .one_hz_enable (one_hz_enable),
    .half_hz_enable(half_hz_enable),
    .value_display (value_display),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_exp"},  32'(expired), 32'd0);
    check({tag, "_1hz"},  32'(one_hz_enable), 32'd0);
    check({tag, "_hhz"},  32'(half_hz_enable), 32'd0);
    check({tag, "_disp"}, 32'(value_display), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // j counts edges since the load (or reset release); n is the loaded duration.
  task automatic countdown(input string tag, input int n, input int len);
    int exp_disp;
    for (int j = 1; j <= len; j++) begin
      step();
      exp_disp = (j >= n * CLK_HZ) ? 0 : n - j / CLK_HZ;
      check({tag, "_disp"}, 32'(value_display), 32'(exp_disp));
      check({tag, "_exp"},  32'(expired), (n > 0 && j == n * CLK_HZ) ? 32'd1 : 32'd0);
      check({tag, "_busy"}, 32'(busy), (j < n * CLK_HZ) ? 32'd1 : 32'd0);
      check({tag, "_1hz"},  32'(one_hz_enable), (j % CLK_HZ == CLK_HZ - 1) ? 32'd1 : 32'd0);
      check({tag, "_hhz"},  32'(half_hz_enable),
            (j % (2 * CLK_HZ) == 2 * CLK_HZ - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic load(input logic [VALUE_W-1:0] v);
    start_timer = 1'b1;
    value       = v;
    step();
    start_timer = 1'b0;
  endtask

  initial begin
    // Reset state while held in reset
    step();
    step();
    check_all_zero("rst");

    // 1: idle strobes after release
    reset = 1'b1;
    countdown("idle", 0, 50);

    // 2: value 3
    load(4'd3);
    check("t2_load_disp", 32'(value_display), 32'd3);
    check("t2_load_busy", 32'(busy), 32'd1);
    check("t2_load_exp",  32'(expired), 32'd0);
    countdown("t2", 3, 35);

    // 3: value 0 expires immediately
    load(4'd0);
    check("t3_exp",  32'(expired), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_disp", 32'(value_display), 32'd0);
    step();
    check("t3_exp_gone", 32'(expired), 32'd0);
    check("t3_busy2",    32'(busy), 32'd0);

    // 4: value 5, restart with 2 at edge +25
    load(4'd5);
    check("t4_load_disp", 32'(value_display), 32'd5);
    countdown("t4a", 5, 24);
    load(4'd2);
    check("t4_reload_disp", 32'(value_display), 32'd2);
    check("t4_reload_busy", 32'(busy), 32'd1);
    check("t4_reload_exp",  32'(expired), 32'd0);
    countdown("t4b", 2, 25);

    // 5: value 4, reset mid-count
    load(4'd4);
    countdown("t5a", 4, 14);
    reset = 1'b0;
    #1;
    check_all_zero("t5_async");
    step();
    step();
    check_all_zero("t5_held");
    reset = 1'b1;
    countdown("t5b", 0, 12);

    // 6: reload on the tick edge where count==1
    load(4'd2);
    countdown("t6a", 2, 19);
    check("t6_pre_disp", 32'(value_display), 32'd1);
    check("t6_pre_tick", 32'(one_hz_enable), 32'd1);
    load(4'd3);
    check("t6_reload_disp", 32'(value_display), 32'd3);
    check("t6_reload_exp",  32'(expired), 32'd0);
    check("t6_reload_busy", 32'(busy), 32'd1);
    countdown("t6b", 3, 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
